// File: rtl/fp_pkg.sv
// fp_pkg: FP32 field layout, helpers and
// accumulator FSM encodings.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_MAX =
    EXP_W'(2 * BIAS + 1);

  localparam logic [FP_W-1:0] FP_POS_ZERO = '0;
  localparam logic [FP_W-2:0] FP_INF_MAG =
    {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NUM,
    RES_ZERO,
    RES_INF,
    RES_KEEP
  } res_t;

  function automatic logic fp_sign(
    input logic [FP_W-1:0] x
  );
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(
    input logic [FP_W-1:0] x
  );
    return x[MAN_W +: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_frac(
    input logic [FP_W-1:0] x
  );
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: split an FP32 word into sign,
// biased exponent and 24b significand.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0]  x,
  output logic             sign,
  output logic [EXP_W-1:0] ex,
  output logic [MAN_W:0]   man,
  output logic             is_zero,
  output logic             is_special
);

  // denormals flush to zero; exp all-ones is Inf/NaN
  always_comb begin
    sign       = fp_sign(x);
    ex         = fp_exp(x);
    is_zero    = (ex == '0);
    is_special = &ex;
    man        = is_zero ? '0 : {1'b1, fp_frac(x)};
  end

endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: running FP32 sum of products,
// truncating multi-cycle add, sticky overflow.
module fp_accumulator
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] fp_in,
  input  logic            in_ovf,
  output logic [FP_W-1:0] acc,
  output logic            acc_valid,
  output logic            ovf,
  output logic            busy
);

  state_t state, state_nx;
  res_t   kind;

  logic [FP_W-1:0]  op;
  logic             sgn;
  logic             sub;
  logic [EXP_W+1:0] ex;
  logic [MAN_W+1:0] man;
  logic [MAN_W:0]   sml;

  logic             a_sign, b_sign;
  logic             a_zero, b_zero;
  logic             a_spec, b_spec;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;

  logic             a_big;
  logic             hi_sign;
  logic [EXP_W-1:0] hi_exp, dif;
  logic [MAN_W:0]   hi_man, lo_man, shf;
  logic [MAN_W+1:0] sum;
  logic [FP_W-1:0]  res;
  logic             ovf_hit;

  fp_unpack u_acc (
    .x          (acc),
    .sign       (a_sign),
    .ex         (a_exp),
    .man        (a_man),
    .is_zero    (a_zero),
    .is_special (a_spec)
  );

  fp_unpack u_op (
    .x          (op),
    .sign       (b_sign),
    .ex         (b_exp),
    .man        (b_man),
    .is_zero    (b_zero),
    .is_special (b_spec)
  );

  assign in_ready = (state == IDLE) && !clear;
  assign busy     = (state != IDLE);

  // order operands by magnitude, align smaller, add/sub
  always_comb begin
    a_big = b_zero ||
      (!a_zero && {a_exp, a_man} >= {b_exp, b_man});
    hi_sign = a_big ? a_sign : b_sign;
    hi_exp  = a_big ? a_exp : b_exp;
    hi_man  = a_big ? a_man : b_man;
    lo_man  = a_big ? b_man : a_man;
    dif     = a_big ? a_exp - b_exp : b_exp - a_exp;
    shf     = (dif >= EXP_W'(25)) ? '0 : lo_man >> dif;
    sum     = sub ? man - {1'b0, sml}
                  : man + {1'b0, sml};
  end

  // pack the final value, detecting exp overflow/underflow
  always_comb begin
    res     = acc;
    ovf_hit = 1'b0;
    case (kind)
      RES_ZERO: res = FP_POS_ZERO;
      RES_INF: begin
        res     = {sgn, FP_INF_MAG};
        ovf_hit = 1'b1;
      end
      RES_NUM: begin
        if (!ex[EXP_W+1] &&
            ex[EXP_W:0] >= {1'b0, EXP_MAX}) begin
          res     = {sgn, FP_INF_MAG};
          ovf_hit = 1'b1;
        end else if (ex[EXP_W+1] || ex == '0) begin
          res = FP_POS_ZERO;
        end else begin
          res = {sgn, ex[EXP_W-1:0], man[MAN_W-1:0]};
        end
      end
      default: res = acc;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // next state; clear wins from any state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready)
          state_nx = in_ovf ? DONE : ALIGN;
      end
      ALIGN: begin
        state_nx = (a_spec || b_spec) ? DONE : ADD;
      end
      ADD: begin
        if (sum == '0 ||
            (sum[MAN_W] && !sum[MAN_W+1]))
          state_nx = DONE;
        else
          state_nx = NORM;
      end
      NORM: begin
        if (man[MAN_W+1] || man[MAN_W-1])
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // datapath and architectural outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op        <= '0;
      kind      <= RES_KEEP;
      sgn       <= 1'b0;
      sub       <= 1'b0;
      ex        <= '0;
      man       <= '0;
      sml       <= '0;
      acc       <= FP_POS_ZERO;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      acc       <= FP_POS_ZERO;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op   <= fp_in;
            kind <= RES_KEEP;
            if (in_ovf) ovf <= 1'b1;
          end
        end
        ALIGN: begin
          sgn  <= (b_spec && !a_spec) ? b_sign : hi_sign;
          sub  <= a_sign ^ b_sign;
          ex   <= {2'b00, hi_exp};
          man  <= {1'b0, hi_man};
          sml  <= shf;
          kind <= a_spec ? RES_KEEP :
                  b_spec ? RES_INF : RES_NUM;
        end
        ADD: begin
          man <= sum;
          if (sum == '0) kind <= RES_ZERO;
        end
        NORM: begin
          if (man[MAN_W+1]) begin
            man <= {1'b0, man[MAN_W+1:1]};
            ex  <= ex + (EXP_W+2)'(1);
          end else begin
            man <= {man[MAN_W:0], 1'b0};
            ex  <= ex - (EXP_W+2)'(1);
          end
        end
        DONE: begin
          acc       <= res;
          acc_valid <= 1'b1;
          if (ovf_hit) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: scoreboard bench with a
// value-level reference model of the accumulator.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_in = '0;
  logic        in_ovf = 1'b0;
  logic [31:0] acc;
  logic        acc_valid;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [32:0] sb[$];
  logic [31:0] macc = '0;
  bit          mov = 1'b0;
  bit          prev_v = 1'b0;

  fp_accumulator dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .in_ovf    (in_ovf),
    .acc       (acc),
    .acc_valid (acc_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(
    string nm, logic [31:0] got, logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endfunction

  // Reference: operands as integer significand * 2^exp.
  // The smaller operand is aligned with its low bits
  // dropped, then the result is truncated.
  // Returns {overflow_event, new_acc}.
  function automatic logic [32:0] ref_add(
    logic [31:0] a, logic [31:0] b
  );
    int ea, eb, ma, mb, s, e, d, t;
    bit sa, sb_, st;
    if (a[30:23] == 8'hFF) return {1'b0, a};
    if (b[30:23] == 8'hFF)
      return {1'b1, b[31], 8'hFF, 23'h0};
    sa = a[31];
    sb_ = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : ((1 << 23) | int'(a[22:0]));
    mb = (eb == 0) ? 0 : ((1 << 23) | int'(b[22:0]));
    if (eb > ea || (eb == ea && mb > ma)) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      st = sa; sa = sb_; sb_ = st;
    end
    d = ea - eb;
    mb = (d >= 25) ? 0 : (mb >> d);
    s = (sa == sb_) ? ma + mb : ma - mb;
    if (s == 0) return 33'h0;
    e = ea;
    while (s >= (1 << 24)) begin s = s >> 1; e++; end
    while (s < (1 << 23)) begin s = s << 1; e--; end
    if (e >= 255) return {1'b1, sa, 8'hFF, 23'h0};
    if (e <= 0) return 33'h0;
    return {1'b0, sa, e[7:0], s[22:0]};
  endfunction

  // monitor: every acc_valid pulse consumes one expectation
  always @(negedge clk) begin
    logic [32:0] w;
    if (resetn && acc_valid) begin
      chk("pulse_width", {31'h0, prev_v}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_acc_valid got=%h want=none",
                 acc);
      end else begin
        w = sb.pop_front();
        chk("acc", acc, w[31:0]);
        chk("ovf", {31'h0, ovf}, {31'h0, w[32]});
      end
    end
    prev_v <= resetn && acc_valid;
  end

  task automatic send(input logic [31:0] v, input bit ov);
    logic [32:0] r;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=busy want=ready");
      return;
    end
    in_valid = 1'b1;
    fp_in = v;
    in_ovf = ov;
    if (ov) begin
      mov = 1'b1;
    end else begin
      r = ref_add(macc, v);
      macc = r[31:0];
      if (r[32]) mov = 1'b1;
    end
    sb.push_back({mov, macc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ovf = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sb.delete();
    macc = '0;
    mov = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 39);
    if (k < 2)       v[30:23] = 8'h00;
    else if (k == 2) v[30:23] = 8'hFF;
    else if (k < 6)  v[30:23] = 8'($urandom_range(250, 254));
    else if (k < 9)  v[30:23] = 8'($urandom_range(1, 4));
    else             v[30:23] = 8'($urandom_range(118, 136));
    return v;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("rst_acc", acc, 32'h0);
    chk("rst_flags", {29'h0, acc_valid, ovf, busy}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);

    // signed product in, then exact cancellation
    do_clear();
    send(32'hC32B0000, 1'b0);
    send(32'h432B0000, 1'b0);
    drain();
    chk("cancel_acc", acc, 32'h0);

    // 1.0 + 2.0, offering a second operand while busy
    do_clear();
    send(32'h3F800000, 1'b0);
    chk("busy_ready", {30'h0, in_ready, busy}, 32'h1);
    in_valid = 1'b1;
    fp_in = 32'h7F7FFFFF;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    send(32'h40000000, 1'b0);
    drain();
    chk("three_acc", acc, 32'h40400000);

    // worst-case normalisation; B's last bit is shifted
    // out before the subtract, leaving 2^-23
    do_clear();
    send(32'h3F800000, 1'b0);
    send(32'hBF7FFFFF, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_valid && n < 40);
    chk("norm_latency", n, 27);
    chk("norm_acc", acc, 32'h34000000);
    drain();

    // underflow to +0
    do_clear();
    send(32'h00800000, 1'b0);
    send(32'h80C00000, 1'b0);
    drain();
    chk("uflow_acc", acc, 32'h0);

    // overflow, sticky ovf, upstream ovf, clear
    do_clear();
    send(32'h7F000000, 1'b0);
    send(32'h7F000000, 1'b0);
    send(32'h3F800000, 1'b1);
    drain();
    chk("ovf_acc", acc, 32'h7F800000);
    chk("ovf_flag", {31'h0, ovf}, 32'h1);
    do_clear();
    chk("clr_acc", acc, 32'h0);
    chk("clr_ovf", {31'h0, ovf}, 32'h0);

    // async reset in the middle of normalisation
    send(32'h3F800000, 1'b0);
    send(32'hBF7FFFFF, 1'b0);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    sb.delete();
    macc = '0;
    mov = 1'b0;
    chk("mid_rst_acc", acc, 32'h0);
    chk("mid_rst_flags",
        {29'h0, acc_valid, ovf, busy}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {30'h0, in_ready, busy}, 32'h2);
    send(32'h40000000, 1'b0);
    drain();

    // clear in the middle of normalisation
    send(32'h3F800000, 1'b0);
    send(32'hBF7FFFFF, 1'b0);
    repeat (8) @(negedge clk);
    do_clear();
    @(negedge clk);
    chk("mid_clr_acc", acc, 32'h0);
    chk("mid_clr_flags",
        {28'h0, acc_valid, ovf, busy, in_ready}, 32'h1);
    send(32'h40400000, 1'b0);
    drain();

    // randomized blocks against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      do_clear();
      for (int i = 0; i < 25; i++)
        send(rnd_op(), ($urandom_range(0, 19) == 0));
      drain();
    end

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
